// File: rtl/serial_tx_controller.sv
// UART-style frame serialiser: start bit, DATA_BITS data bits LSB first, one
// stop bit. Word-level valid/ready upstream; bit timing and bit sequencing
// are owned here.
module serial_tx_controller #(
  parameter int DATA_BITS = 8,
  parameter int CNT_BITS  = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CNT_BITS-1:0]  bit_period,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 serial_out,
  output logic                 busy,
  output logic                 done
);

  localparam int IDX_BITS = $clog2(DATA_BITS + 1);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, state_nxt;
  logic [CNT_BITS-1:0]  timer, per_q;
  logic [IDX_BITS-1:0]  bit_idx;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 accept, roll, last_bit;

  // tx_ready is registered as (next state == IDLE), so it tracks state exactly
  assign accept   = tx_valid && tx_ready;
  // timer runs 1..per_q while framing; strobe marks the last clock of a bit
  assign roll     = (state != IDLE) && (timer == per_q);
  assign last_bit = (bit_idx == LAST_IDX);

  // Next-state and next shift-register contents
  always_comb begin
    state_nxt = state;
    shift_nxt = shift;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = START;
          shift_nxt = tx_data;
        end
      end
      START: begin
        if (roll) state_nxt = DATA;
      end
      DATA: begin
        if (roll) begin
          if (last_bit) state_nxt = STOP;
          else          shift_nxt = shift >> 1;
        end
      end
      STOP: begin
        if (roll) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters, latched word/period and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift      <= '0;
      per_q      <= '0;
      timer      <= '0;
      bit_idx    <= '0;
      serial_out <= 1'b1;
      busy       <= 1'b0;
      tx_ready   <= 1'b1;
      done       <= 1'b0;
    end else begin
      state <= state_nxt;
      shift <= shift_nxt;

      // a zero period would never roll over; run it as one clock per bit
      if (accept)
        per_q <= (bit_period == '0) ? CNT_BITS'(1) : bit_period;

      // restart at the first count on accept and on every bit boundary
      if (accept || roll)     timer <= CNT_BITS'(1);
      else if (state != IDLE) timer <= timer + CNT_BITS'(1);

      // index restarts on entry to DATA and stops at the last bit
      if (state == START && roll)
        bit_idx <= '0;
      else if (state == DATA && roll && !last_bit)
        bit_idx <= bit_idx + IDX_BITS'(1);

      // outputs follow the state being entered, so the line changes
      // in the same cycle the new state becomes current
      serial_out <= (state_nxt == DATA) ? shift_nxt[0] : (state_nxt != START);
      busy       <= (state_nxt != IDLE);
      tx_ready   <= (state_nxt == IDLE);
      done       <= (state == STOP) && roll;
    end
  end

endmodule

// File: tb/tb_serial_tx_controller.sv
// Directed bench for serial_tx_controller: reset, frame timing/content,
// zero period, back-to-back frames, mid-frame reset, input changes in-frame.
module tb_serial_tx_controller;

  localparam int DATA_BITS = 8;
  localparam int CNT_BITS  = 10;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [CNT_BITS-1:0]  bit_period;
  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready, serial_out, busy, done;

  int n_chk  = 0;
  int n_fail = 0;

  serial_tx_controller #(.DATA_BITS(DATA_BITS), .CNT_BITS(CNT_BITS)) dut (
    .clk(clk), .rst(rst), .bit_period(bit_period), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready), .serial_out(serial_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // present a word at a falling edge; it is accepted on the next rising edge
  task automatic accept_word(input logic [7:0] d, input int per, input bit hold);
    @(negedge clk);
    tx_valid   = 1'b1;
    tx_data    = d;
    bit_period = CNT_BITS'(per);
    @(posedge clk);
    #1;
    if (!hold) tx_valid = 1'b0;
  endtask

  // expected line level k clocks into a frame of data d with period per
  function automatic logic exp_bit(input logic [7:0] d, input int per, input int k);
    int b;
    b = k / per;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return d[b-1];
  endfunction

  // walk a whole frame starting just after the accept edge, then the done cycle
  task automatic frame_check(input logic [7:0] d, input int per, input bit mutate);
    for (int k = 0; k < 10 * per; k++) begin
      @(negedge clk);
      chk($sformatf("line k=%0d", k), serial_out, exp_bit(d, per, k));
      chk("busy in frame", busy, 1);
      chk("ready in frame", tx_ready, 0);
      chk("done in frame", done, 0);
      if (mutate && k == 2) begin
        tx_data    = ~d;
        bit_period = CNT_BITS'(7);
      end
    end
    @(negedge clk);
    chk("done pulse", done, 1);
    chk("ready at done", tx_ready, 1);
    chk("busy at done", busy, 0);
    chk("idle line", serial_out, 1);
  endtask

  initial begin
    rst = 1'b1; tx_valid = 1'b1; tx_data = 8'h5A; bit_period = CNT_BITS'(3);

    // 1: reset held with valid asserted
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst line", serial_out, 1);
      chk("rst ready", tx_ready, 1);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
    end
    rst = 1'b0; tx_valid = 1'b0;
    @(negedge clk);
    chk("post-rst busy", busy, 0);
    chk("post-rst ready", tx_ready, 1);

    // 2: period 4, A5
    accept_word(8'hA5, 4, 1'b0);
    frame_check(8'hA5, 4, 1'b0);
    @(negedge clk);
    chk("done one cycle", done, 0);

    // 3: period 0 runs as 1
    accept_word(8'h01, 0, 1'b0);
    frame_check(8'h01, 1, 1'b0);

    // 4: back-to-back with valid held
    accept_word(8'h00, 2, 1'b1);
    frame_check(8'h00, 2, 1'b0);
    tx_data = 8'hFF;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    frame_check(8'hFF, 2, 1'b0);

    // 5: reset in the third data bit (clocks 12..15 of a period-4 frame)
    accept_word(8'hA5, 4, 1'b0);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      chk($sformatf("pre-rst k=%0d", k), serial_out, exp_bit(8'hA5, 4, k));
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst line", serial_out, 1);
    chk("midrst ready", tx_ready, 1);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no done after rst", done, 0);
      chk("idle after rst", serial_out, 1);
    end
    accept_word(8'h3C, 3, 1'b0);
    frame_check(8'h3C, 3, 1'b0);

    // 6: inputs change mid-frame
    accept_word(8'h96, 3, 1'b0);
    frame_check(8'h96, 3, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
